// File: rtl/pcf8591_scan_ctrl.sv
// Round-robin PCF8591 ADC scan sequencer driving a byte-level I2C master engine.
// Define PCF8591_DAC_EN to enable the analog output and insert the DAC byte write.
module pcf8591_scan_ctrl #(
    parameter int         SCAN_DIV = 50000,
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter logic [3:0] CH_MASK  = 4'b1111
) (
    input  logic        sysclk,
    input  logic        reset,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd,
    output logic [7:0]  tx_data,
    input  logic        cmd_done,
    input  logic [7:0]  rx_data,
    input  logic        ack_err,
    input  logic [7:0]  dac_value,
    output logic [31:0] ch_data,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    output logic        bus_err,
    output logic        busy
);

    localparam int TMR_W = $clog2(SCAN_DIV);

    localparam logic [2:0] CMD_START     = 3'd0;
    localparam logic [2:0] CMD_STOP      = 3'd1;
    localparam logic [2:0] CMD_WRITE     = 3'd2;
    localparam logic [2:0] CMD_READ_ACK  = 3'd3;
    localparam logic [2:0] CMD_READ_NACK = 3'd4;

`ifdef PCF8591_DAC_EN
    localparam logic DAC_BIT = 1'b1;
`else
    localparam logic DAC_BIT = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE,
        W_START,
        W_ADDR,
        W_CTRL,
`ifdef PCF8591_DAC_EN
        W_DAC,
`endif
        W_STOP,
        R_START,
        R_ADDR,
        R_DUMMY,
        R_DATA,
        R_STOP,
        UPDATE,
        ERR_STOP
    } state_t;

    function automatic logic [1:0] first_ch(input logic [3:0] mask);
        first_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) first_ch = 2'(i);
        end
    endfunction

    // Nearest enabled channel above cur, wrapping; stays on cur if it is the only one.
    function automatic logic [1:0] next_ch(input logic [1:0] cur);
        logic [1:0] c;
        next_ch = cur;
        for (int i = 3; i >= 1; i--) begin
            c = cur + 2'(i);
            if (CH_MASK[c]) next_ch = c;
        end
    endfunction

    function automatic logic is_write(input state_t s);
        case (s)
            W_ADDR, W_CTRL, R_ADDR: is_write = 1'b1;
`ifdef PCF8591_DAC_EN
            W_DAC:                  is_write = 1'b1;
`endif
            default:                is_write = 1'b0;
        endcase
    endfunction

    function automatic state_t after_done(input state_t s);
        case (s)
            W_START:  after_done = W_ADDR;
            W_ADDR:   after_done = W_CTRL;
`ifdef PCF8591_DAC_EN
            W_CTRL:   after_done = W_DAC;
            W_DAC:    after_done = W_STOP;
`else
            W_CTRL:   after_done = W_STOP;
`endif
            W_STOP:   after_done = R_START;
            R_START:  after_done = R_ADDR;
            R_ADDR:   after_done = R_DUMMY;
            R_DUMMY:  after_done = R_DATA;
            R_DATA:   after_done = R_STOP;
            R_STOP:   after_done = UPDATE;
            default:  after_done = IDLE;
        endcase
    endfunction

    localparam logic [1:0] FIRST_CH = first_ch(CH_MASK);

    state_t           state_q, state_d;
    logic             cmd_valid_d;
    logic             pend_q, pend_d;
    logic [TMR_W-1:0] timer_q;
    logic             tc;
    logic             tick_q;
    logic [1:0]       ch_q;
    logic [7:0]       rx_q;
    logic [7:0]       dac_q;

    assign tc   = (timer_q == TMR_W'(SCAN_DIV - 1));
    assign busy = (state_q != IDLE);

`ifdef PCF8591_DAC_EN
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            dac_q <= 8'h00;
        end else if (state_q == W_ADDR && state_d == W_CTRL) begin
            dac_q <= dac_value;
        end
    end
`else
    logic unused_dac;
    assign dac_q      = 8'h00;
    assign unused_dac = ^{dac_value, dac_q};
`endif

    // Command and payload are decoded from the state, so they hold for the whole handshake.
    always_comb begin
        cmd     = CMD_START;
        tx_data = 8'h00;
        case (state_q)
            W_ADDR: begin
                cmd     = CMD_WRITE;
                tx_data = {DEV_ADDR, 1'b0};
            end
            W_CTRL: begin
                cmd     = CMD_WRITE;
                tx_data = {1'b0, DAC_BIT, 4'b0000, ch_q};
            end
`ifdef PCF8591_DAC_EN
            W_DAC: begin
                cmd     = CMD_WRITE;
                tx_data = dac_q;
            end
`endif
            R_ADDR: begin
                cmd     = CMD_WRITE;
                tx_data = {DEV_ADDR, 1'b1};
            end
            W_STOP, R_STOP, ERR_STOP: cmd = CMD_STOP;
            R_DUMMY:                  cmd = CMD_READ_ACK;
            R_DATA:                   cmd = CMD_READ_NACK;
            default:                  ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid;
        pend_d      = pend_q;
        if (cmd_valid && cmd_ready) begin
            cmd_valid_d = 1'b0;
            pend_d      = 1'b1;
        end
        if (pend_q && cmd_done) begin
            pend_d = 1'b0;
            if (is_write(state_q) && ack_err) begin
                state_d = ERR_STOP;
            end else begin
                state_d = after_done(state_q);
            end
            cmd_valid_d = (state_d != IDLE) && (state_d != UPDATE);
        end
        case (state_q)
            IDLE: begin
                if (tick_q && (CH_MASK != 4'b0000)) begin
                    state_d     = W_START;
                    cmd_valid_d = 1'b1;
                end
            end
            UPDATE:  state_d = IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cmd_valid    <= 1'b0;
            pend_q       <= 1'b0;
            timer_q      <= '0;
            tick_q       <= 1'b0;
            ch_q         <= FIRST_CH;
            rx_q         <= 8'h00;
            ch_data      <= 32'h0000_0000;
            sample_valid <= 1'b0;
            sample_ch    <= 2'd0;
            bus_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_valid    <= cmd_valid_d;
            pend_q       <= pend_d;
            timer_q      <= tc ? '0 : timer_q + 1'b1;
            tick_q       <= tc;
            sample_valid <= 1'b0;
            if (state_q == R_DATA && state_d == R_STOP) begin
                rx_q <= rx_data;
            end
            if (state_q == R_STOP && state_d == UPDATE) begin
                ch_data[{ch_q, 3'b000} +: 8] <= rx_q;
                sample_valid                 <= 1'b1;
                sample_ch                    <= ch_q;
            end
            if (state_d == ERR_STOP && state_q != ERR_STOP) begin
                bus_err <= 1'b1;
            end
            if (state_q == UPDATE || (state_q == ERR_STOP && state_d == IDLE)) begin
                ch_q <= next_ch(ch_q);
            end
        end
    end

endmodule
